// File: rtl/btn_conditioner.sv
// Four-channel pushbutton conditioner: 2-flop synchronizer, debounce FSM and
// auto-repeat timer per channel. The channels are fully independent. Each one
// produces a one-cycle move pulse per accepted press and per repeat, plus a
// debounced level.
//
// Parameter limits: every *_CYCLES/DELAY/PERIOD value must be >= 2.
// REPEAT_PERIOD must also exceed the downstream move cooldown.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 15_000_000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_pulse,
    output logic [3:0] btn_level
);

    localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                                      DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CYC = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StHeld,
        StRepeat,
        StReleaseWait
    } state_e;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic             sync1_q;
        logic             sync_q;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pulse_q, pulse_d;
        logic             level_q, level_d;

        // Two-flop synchronizer for the asynchronous raw button.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync_q  <= 1'b0;
            end else begin
                sync1_q <= btn_in[i];
                sync_q  <= sync1_q;
            end
        end

        // FSM state, timer and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
                level_q <= level_d;
            end
        end

        // Next-state logic: a loss of the synchronized input always takes
        // priority over a timer expiry, and every transition restarts the timer.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q + CNT_ONE;
            pulse_d = 1'b0;
            level_d = level_q;
            case (state_q)
                StIdle: begin
                    // Timer is unused while idle; keep it parked at zero.
                    cnt_d = '0;
                    if (sync_q) begin
                        state_d = StPressWait;
                    end
                end
                StPressWait: begin
                    if (!sync_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        level_d = 1'b1;
                    end
                end
                StHeld: begin
                    if (!sync_q) begin
                        state_d = StReleaseWait;
                        cnt_d   = '0;
                    end else if (cnt_q == DLY_LAST) begin
                        if (REPEAT_EN) begin
                            state_d = StRepeat;
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                        end else begin
                            // Without auto-repeat, park the timer so it never wraps.
                            cnt_d = cnt_q;
                        end
                    end
                end
                StRepeat: begin
                    if (!sync_q) begin
                        state_d = StReleaseWait;
                        cnt_d   = '0;
                    end else if (cnt_q == PER_LAST) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end
                end
                StReleaseWait: begin
                    if (sync_q) begin
                        // Release bounce: back to held, and the repeat delay restarts.
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign btn_pulse[i] = pulse_q;
        assign btn_level[i] = level_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncy stimulus,
// checked every cycle against a run-length reference model. One DUT has
// auto-repeat enabled and a second one has it disabled.
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_in;
    logic [3:0] p_rep, l_rep, p_norep, l_norep;

    int checks = 0;
    int errors = 0;

    // Reference model state: input delay line, run lengths of the
    // synchronized input, and the debounced level.
    logic [3:0] s1, s2;
    int         run1[4];
    int         run0[4];
    int         origin[4];
    logic [3:0] m_level, m_pulse_rep, m_pulse_norep;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1'b1)
    ) dut_rep (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .btn_pulse(p_rep),
        .btn_level(l_rep)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1'b0)
    ) dut_norep (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .btn_pulse(p_norep),
        .btn_level(l_norep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        s1 = '0;
        s2 = '0;
        m_level = '0;
        m_pulse_rep = '0;
        m_pulse_norep = '0;
        for (int c = 0; c < 4; c++) begin
            run1[c] = 0;
            run0[c] = 0;
            origin[c] = 0;
        end
    endtask

    // The level changes once the synchronized input has held the opposite
    // value for D+1 sampled edges. Repeats are timed from the moment the
    // press was accepted, or from the moment a release bounce ended.
    task automatic model_edge(input logic [3:0] b);
        int held;
        for (int c = 0; c < 4; c++) begin
            logic x;
            x = s2[c];
            m_pulse_rep[c] = 1'b0;
            m_pulse_norep[c] = 1'b0;
            if (x) begin
                run1[c]++;
                run0[c] = 0;
            end else begin
                run0[c]++;
                run1[c] = 0;
            end
            if (!m_level[c]) begin
                if (x && run1[c] == D + 1) begin
                    m_level[c] = 1'b1;
                    m_pulse_rep[c] = 1'b1;
                    m_pulse_norep[c] = 1'b1;
                    origin[c] = run1[c];
                end
            end else if (!x) begin
                if (run0[c] == D + 1) m_level[c] = 1'b0;
            end else begin
                if (run1[c] == 1) origin[c] = 1;
                held = run1[c] - origin[c];
                if (held >= RD && ((held - RD) % RP) == 0) m_pulse_rep[c] = 1'b1;
            end
        end
        s2 = s1;
        s1 = b;
    endtask

    // Drive one input value through one clock edge, then compare both DUTs.
    task automatic step(input logic [3:0] b);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check("pulse_rep", 32'(p_rep), 32'(m_pulse_rep));
        check("pulse_norep", 32'(p_norep), 32'(m_pulse_norep));
        check("level_rep", 32'(l_rep), 32'(m_level));
        check("level_norep", 32'(l_norep), 32'(m_level));
    endtask

    // Hold a value for n edges; count pulses on one bit and note the first one.
    task automatic hold(input logic [3:0] b, input int n, input int bi,
                        output int cnt, output int first);
        cnt = 0;
        first = -1;
        for (int e = 0; e < n; e++) begin
            step(b);
            if (p_rep[bi]) begin
                cnt++;
                if (first < 0) first = e;
            end
        end
    endtask

    // Assert reset between clock edges; the outputs must clear at once.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pulse", 32'(p_rep | p_norep), 32'd0);
        check("async_rst_level", 32'(l_rep | l_norep), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, first, dummy;
        int edges[$];
        int exp_edges[6];
        int hold_left[4];
        logic [3:0] cur;
        logic lvl_ok;

        exp_edges[0] = 6;
        exp_edges[1] = 26;
        exp_edges[2] = 34;
        exp_edges[3] = 42;
        exp_edges[4] = 50;
        exp_edges[5] = 58;

        // Reset with every button held.
        rst_n = 1'b0;
        btn_in = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulse", 32'(p_rep), 32'd0);
        check("reset_level", 32'(l_rep), 32'd0);
        rst_n = 1'b1;
        hold(4'hF, 10, 0, cnt, first);
        check("post_reset_first_edge", 32'(first), 32'd6);
        check("post_reset_count", 32'(cnt), 32'd1);
        hold(4'h0, 12, 0, cnt, dummy);

        // Clean press of U for 15 cycles.
        hold(4'h4, 15, 2, cnt, first);
        check("clean_first_edge", 32'(first), 32'd6);
        check("clean_count", 32'(cnt), 32'd1);
        first = -1;
        for (int e = 0; e < 12; e++) begin
            step(4'h0);
            if (!l_rep[2] && first < 0) first = e;
        end
        check("clean_level_fall", 32'(first), 32'd6);

        // Bounce on L, then a stable press.
        cnt = 0;
        step(4'h1); cnt += int'(p_rep[0]);
        step(4'h0); cnt += int'(p_rep[0]);
        step(4'h1); cnt += int'(p_rep[0]);
        step(4'h1); cnt += int'(p_rep[0]);
        step(4'h0); cnt += int'(p_rep[0]);
        check("bounce_no_pulse", 32'(cnt), 32'd0);
        hold(4'h1, 12, 0, cnt, first);
        check("bounce_first_edge", 32'(first), 32'd6);
        check("bounce_count", 32'(cnt), 32'd1);
        hold(4'h0, 12, 0, cnt, dummy);

        // Auto-repeat on R for 60 cycles.
        cnt = 0;
        for (int e = 0; e < 60; e++) begin
            step(4'h2);
            if (p_rep[1]) edges.push_back(e);
            cnt += int'(p_norep[1]);
        end
        check("repeat_count", 32'(edges.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < edges.size()) check("repeat_edge", 32'(edges[k]), 32'(exp_edges[k]));
        end
        check("norep_count", 32'(cnt), 32'd1);
        hold(4'h0, 20, 1, cnt, dummy);
        check("repeat_after_release", 32'(cnt), 32'd0);

        // Release glitch on D while held.
        hold(4'h8, 10, 3, cnt, first);
        check("glitch_first_edge", 32'(first), 32'd6);
        lvl_ok = 1'b1;
        cnt = 0;
        first = -1;
        for (int e = 10; e < 42; e++) begin
            step((e == 10 || e == 11) ? 4'h0 : 4'h8);
            if (!l_rep[3]) lvl_ok = 1'b0;
            if (p_rep[3]) begin
                cnt++;
                if (first < 0) first = e;
            end
        end
        check("glitch_level_held", 32'(lvl_ok), 32'd1);
        check("glitch_repeat_count", 32'(cnt), 32'd1);
        check("glitch_repeat_edge", 32'(first), 32'd34);
        hold(4'h0, 12, 3, cnt, dummy);

        // Simultaneous L and U, then reset in the middle of repeating.
        for (int e = 0; e < 31; e++) begin
            step(4'h5);
            if (e == 6) check("simul_pulse", 32'(p_rep), 32'h5);
            if (e == 7) check("simul_pulse_width", 32'(p_rep), 32'h0);
        end
        check("simul_level", 32'(l_rep), 32'h5);
        mid_reset();
        hold(4'h0, 4, 0, cnt, dummy);

        // Random bouncy stimulus on all four channels.
        cur = '0;
        for (int c = 0; c < 4; c++) hold_left[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold_left[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    hold_left[c] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6))
                                                               : int'($urandom_range(7, 60));
                end
                hold_left[c]--;
            end
            step(cur);
            if (n == 1500) mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
